tc_clk_gate_ctrl: RTL and testbench
===================================

// Module: tc_clk_gate_ctrl
// PURPOSE
//  Idle-driven controller that sequences the en_i input of a tc_clk_gating cell.
//  - Gates the clock of one downstream domain after a programmable run of idle cycles.
//  - Re-enables it on activity or on a wake request, then grants the request once
//    the clock has been stable for WakeCycles.
//  - Runs on the ungated clock, upstream of the gate; also counts gated cycles for
//    power profiling.
// PARAMETERS
//  CntWidth    16  width of idle-threshold and wake counters
//  WakeCycles  4   cycles the clock must run after un-gating before RUN (>=1)
//  StatWidth   32  width of gated-cycle statistics counter
// PORTS
//  clk_i              in   1          ungated clock; single clock domain
//  rst_ni             in   1          asynchronous reset, active-low
//  test_mode_i        in   1          DFT: forces clock enabled, FSM held in RUN
//  cfg_enable_i       in   1          1 = automatic gating allowed
//  cfg_idle_thresh_i  in   CntWidth   idle cycles before gating (0 treated as 1)
//  idle_i             in   1          downstream domain reports idle
//  wake_req_i         in   1          4-phase wake request (level)
//  wake_ack_o         out  1          4-phase wake acknowledge
//  clk_en_o           out  1          to tc_clk_gating en_i
//  gated_o            out  1          status: clock currently gated
//  stat_clr_i         in   1          synchronous clear of gated_cycles_o
//  gated_cycles_o     out  StatWidth  saturating count of cycles spent in GATED
// BEHAVIOUR
//  Reset values (async on rst_ni low, any state):
//   - state=RUN, clk_en_o=1, gated_o=0, wake_ack_o=0, counters=0.
//  Output timing:
//   - All outputs registered.
//   - Only exception: clk_en_o = en_q | test_mode_i (single combinational path).
//  States:
//   - RUN: en_q=1. If cfg_enable_i & idle_i & !wake_req_i & !test_mode_i ->
//     IDLE_WAIT, cnt=1.
//   - IDLE_WAIT: en_q=1.
//     - Abort to RUN if !idle_i | wake_req_i | !cfg_enable_i | test_mode_i.
//     - Else if cnt >= max(thresh,1) -> GATED; else cnt++.
//     - Net: threshold T gives en_q low exactly T+1 cycles after the RUN-exit
//       cycle (T=0 and T=1 identical).
//     - thresh is sampled every cycle; lowering it mid-count gates at the next
//       compare.
//   - GATED: en_q=0, gated_o=1.
//     - Exit on !idle_i | wake_req_i | !cfg_enable_i | test_mode_i -> WAKE,
//       cnt=0; en_q=1 in the cycle after the exit condition.
//     - Exit to RUN instead of WAKE when test_mode_i.
//   - WAKE: en_q=1, gated_o=0. cnt++ each cycle; at cnt==WakeCycles-1 -> RUN.
//     No abort; idle_i ignored.
//  Wake handshake (4-phase):
//   - ack_q sets the cycle after wake_req_i is sampled high while state==RUN.
//   - Held while req stays high; clears the cycle after req sampled low.
//   - req must not rise again until ack is low (protocol violation, assert).
//   - From GATED, ack latency = 1 (exit) + WakeCycles + 1 cycles.
//   - In RUN the FSM never leaves RUN while wake_req_i or wake_ack_o is high.
//  Statistics:
//   - gated_cycles_o increments each cycle state==GATED; saturates at all-ones.
//   - stat_clr_i has priority over increment (clears that cycle).
//  Simultaneous events:
//   - wake_req_i and idle_i in same RUN cycle -> stays RUN, ack.
//   - cfg_enable_i dropped in GATED -> normal WAKE sequence, no skipping.
//  Reset mid-operation: immediate RUN with clk_en_o=1; no ack outstanding.
// STRUCTURE
//  - tc_clk_gate_ctrl_pkg: state_e {RUN, IDLE_WAIT, GATED, WAKE} (2-bit enum),
//    default params.
//  - One FSM process plus one shared counter (idle/wake reuse, CntWidth).
//  - Sub-module: none; the statistics counter is inline.
//  - Assertions: WakeCycles>=1; en_q stable low only in GATED; ack never
//    high outside RUN.
// TESTING
//  1. Reset, thresh=3, enable=1, idle=1 held -> clk_en_o low exactly 4 cycles
//     after RUN exit; gated_o=1.
//  2. Gated, idle_i drops -> clk_en_o=1 next cycle, RUN after 4 (WakeCycles)
//     more; gated_cycles_o equals gated cycle count.
//  3. Gated, wake_req_i=1 -> ack after 6 cycles; drop req -> ack low next cycle;
//     no regate while req/ack high.
//  4. IDLE_WAIT at cnt=2, idle_i glitches low 1 cycle -> back to RUN, full T
//     count restarts.
//  5. test_mode_i=1 during GATED -> clk_en_o=1 same cycle; FSM RUN next cycle;
//     no gating while held.
//  6. rst_ni low in WAKE and GATED -> outputs at reset values asynchronously;
//     thresh=0 behaves as 1; stat saturates.

Source files
------------

// File: rtl/tc_clk_gate_ctrl_pkg.sv
// Shared types and default parameters for the idle-driven clock-gate controller.
package tc_clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } state_e;

    localparam int CNT_WIDTH   = 16;
    localparam int WAKE_CYCLES = 4;
    localparam int STAT_WIDTH  = 32;

endpackage

// File: rtl/tc_clk_gate_ctrl.sv
// Sequences the enable of a downstream clock gate from idle/wake activity and
// keeps a saturating count of cycles spent gated.
module tc_clk_gate_ctrl
    import tc_clk_gate_ctrl_pkg::*;
#(
    parameter int CntWidth   = CNT_WIDTH,
    parameter int WakeCycles = WAKE_CYCLES,
    parameter int StatWidth  = STAT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 cfg_enable_i,
    input  logic [CntWidth-1:0]  cfg_idle_thresh_i,
    input  logic                 idle_i,
    input  logic                 wake_req_i,
    output logic                 wake_ack_o,
    output logic                 clk_en_o,
    output logic                 gated_o,
    input  logic                 stat_clr_i,
    output logic [StatWidth-1:0] gated_cycles_o
);

    localparam logic [CntWidth-1:0] WAKE_LAST = CntWidth'(WakeCycles - 1);

    if (WakeCycles < 1) begin : g_wake_cycles_check
        $error("WakeCycles must be at least 1");
    end

    state_e                state;
    logic [CntWidth-1:0]   cnt;
    logic [CntWidth-1:0]   thresh_eff;
    logic                  en_q;
    logic                  gated_q;
    logic                  ack_q;
    logic [StatWidth-1:0]  stat_q;
    logic                  go_idle;
    logic                  leave_idle;

    assign thresh_eff = (cfg_idle_thresh_i == '0) ? CntWidth'(1) : cfg_idle_thresh_i;

    // An outstanding handshake keeps the FSM in RUN, so ack can only ever be seen in RUN.
    assign go_idle    = cfg_enable_i & idle_i & ~wake_req_i & ~test_mode_i & ~ack_q;
    assign leave_idle = ~idle_i | wake_req_i | ~cfg_enable_i | test_mode_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= RUN;
            cnt     <= '0;
            en_q    <= 1'b1;
            gated_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (go_idle) begin
                        state <= IDLE_WAIT;
                        cnt   <= CntWidth'(1);
                    end
                end
                IDLE_WAIT: begin
                    if (leave_idle) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt >= thresh_eff) begin
                        state   <= GATED;
                        en_q    <= 1'b0;
                        gated_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CntWidth'(1);
                    end
                end
                GATED: begin
                    if (test_mode_i) begin
                        state   <= RUN;
                        cnt     <= '0;
                        en_q    <= 1'b1;
                        gated_q <= 1'b0;
                    end else if (leave_idle) begin
                        state   <= WAKE;
                        cnt     <= '0;
                        en_q    <= 1'b1;
                        gated_q <= 1'b0;
                    end
                end
                WAKE: begin
                    if (cnt == WAKE_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntWidth'(1);
                    end
                end
                default: begin
                    state   <= RUN;
                    cnt     <= '0;
                    en_q    <= 1'b1;
                    gated_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
        end else if (!wake_req_i) begin
            ack_q <= 1'b0;
        end else if (state == RUN) begin
            ack_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_q <= '0;
        end else if (stat_clr_i) begin
            stat_q <= '0;
        end else if (state == GATED && stat_q != '1) begin
            stat_q <= stat_q + StatWidth'(1);
        end
    end

    assign clk_en_o       = en_q | test_mode_i;
    assign gated_o        = gated_q;
    assign wake_ack_o     = ack_q;
    assign gated_cycles_o = stat_q;

    a_en_low_only_gated : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !en_q |-> state == GATED);

    a_ack_only_in_run : assert property (
        @(posedge clk_i) disable iff (!rst_ni) ack_q |-> state == RUN);

    a_req_waits_for_ack_low : assert property (
        @(posedge clk_i) disable iff (!rst_ni) $rose(wake_req_i) |-> !ack_q);

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
// Directed self-checking bench for tc_clk_gate_ctrl: gating timing, wake
// handshake, test mode, reset and statistics saturation.
module tb_tc_clk_gate_ctrl;
    import tc_clk_gate_ctrl_pkg::*;

    localparam int CW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          test_mode;
    logic          enable;
    logic [CW-1:0] thresh;
    logic          idle;
    logic          req;
    logic          ack;
    logic          clk_en;
    logic          gated;
    logic          stat_clr;
    logic [SW-1:0] stats;

    int checks = 0;
    int errors = 0;

    tc_clk_gate_ctrl #(
        .CntWidth  (CW),
        .WakeCycles(4),
        .StatWidth (SW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .test_mode_i      (test_mode),
        .cfg_enable_i     (enable),
        .cfg_idle_thresh_i(thresh),
        .idle_i           (idle),
        .wake_req_i       (req),
        .wake_ack_o       (ack),
        .clk_en_o         (clk_en),
        .gated_o          (gated),
        .stat_clr_i       (stat_clr),
        .gated_cycles_o   (stats)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        test_mode = 1'b0;
        enable    = 1'b1;
        thresh    = 16'd3;
        idle      = 1'b0;
        req       = 1'b0;
        stat_clr  = 1'b0;

        // Reset state
        tick(2);
        checkOutput("rst_clk_en", 32'(clk_en), 32'd1);
        checkOutput("rst_gated", 32'(gated), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_stats", 32'(stats), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(RUN));
        rst_n = 1'b1;

        // Threshold 3: enable drops exactly 4 edges after leaving RUN
        idle = 1'b1;
        tick(1);
        checkOutput("s1_state_iw", 32'(dut.state), 32'(IDLE_WAIT));
        checkOutput("s1_en_e0", 32'(clk_en), 32'd1);
        tick(2);
        checkOutput("s1_en_e2", 32'(clk_en), 32'd1);
        tick(1);
        checkOutput("s1_en_e3", 32'(clk_en), 32'd0);
        checkOutput("s1_gated", 32'(gated), 32'd1);

        // Idle drops while gated: wake sequence of 4 cycles, 3 gated cycles counted
        tick(2);
        idle = 1'b0;
        tick(1);
        checkOutput("s2_en_wake", 32'(clk_en), 32'd1);
        checkOutput("s2_gated", 32'(gated), 32'd0);
        checkOutput("s2_stats", 32'(stats), 32'd3);
        checkOutput("s2_state_wake", 32'(dut.state), 32'(WAKE));
        tick(3);
        checkOutput("s2_state_wake3", 32'(dut.state), 32'(WAKE));
        tick(1);
        checkOutput("s2_state_run", 32'(dut.state), 32'(RUN));
        checkOutput("s2_stats_hold", 32'(stats), 32'd3);

        // Wake request from GATED: ack 6 edges later, no regate while req/ack high
        idle = 1'b1;
        tick(4);
        checkOutput("s3_gated", 32'(gated), 32'd1);
        req = 1'b1;
        tick(1);
        checkOutput("s3_en_exit", 32'(clk_en), 32'd1);
        checkOutput("s3_ack_e1", 32'(ack), 32'd0);
        tick(4);
        checkOutput("s3_ack_e5", 32'(ack), 32'd0);
        checkOutput("s3_state_run", 32'(dut.state), 32'(RUN));
        tick(1);
        checkOutput("s3_ack_e6", 32'(ack), 32'd1);
        tick(3);
        checkOutput("s3_ack_held", 32'(ack), 32'd1);
        checkOutput("s3_no_regate_en", 32'(clk_en), 32'd1);
        checkOutput("s3_no_regate_gated", 32'(gated), 32'd0);
        req = 1'b0;
        tick(1);
        checkOutput("s3_ack_drop", 32'(ack), 32'd0);
        checkOutput("s3_run_after_drop", 32'(dut.state), 32'(RUN));
        tick(1);
        checkOutput("s3_iw_again", 32'(dut.state), 32'(IDLE_WAIT));
        tick(2);
        checkOutput("s3_en_before_regate", 32'(clk_en), 32'd1);
        tick(1);
        checkOutput("s3_regated", 32'(clk_en), 32'd0);

        // Test mode while gated: enable immediately, RUN next edge, held there
        test_mode = 1'b1;
        #1;
        checkOutput("s5_en_comb", 32'(clk_en), 32'd1);
        tick(1);
        checkOutput("s5_state_run", 32'(dut.state), 32'(RUN));
        checkOutput("s5_gated", 32'(gated), 32'd0);
        tick(8);
        checkOutput("s5_held_state", 32'(dut.state), 32'(RUN));
        checkOutput("s5_held_gated", 32'(gated), 32'd0);

        // Idle glitch at cnt=2 aborts; the full count restarts afterwards
        test_mode = 1'b0;
        tick(2);
        checkOutput("s4_iw_cnt2", 32'(dut.state), 32'(IDLE_WAIT));
        idle = 1'b0;
        tick(1);
        checkOutput("s4_abort_run", 32'(dut.state), 32'(RUN));
        idle = 1'b1;
        tick(3);
        checkOutput("s4_en_restart", 32'(clk_en), 32'd1);
        tick(1);
        checkOutput("s4_gated_after_full", 32'(clk_en), 32'd0);

        // Enable dropped while gated runs the full wake sequence
        enable = 1'b0;
        tick(1);
        checkOutput("s6_cfg_wake", 32'(dut.state), 32'(WAKE));
        checkOutput("s6_cfg_en", 32'(clk_en), 32'd1);
        tick(3);
        checkOutput("s6_cfg_wake3", 32'(dut.state), 32'(WAKE));
        tick(1);
        checkOutput("s6_cfg_run", 32'(dut.state), 32'(RUN));
        tick(2);
        checkOutput("s6_cfg_stay_run", 32'(dut.state), 32'(RUN));
        enable = 1'b1;

        // Threshold 0 behaves as 1; then asynchronous reset while gated
        thresh = 16'd0;
        tick(1);
        checkOutput("s6_t0_en_e0", 32'(clk_en), 32'd1);
        tick(1);
        checkOutput("s6_t0_gated", 32'(clk_en), 32'd0);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s6_rstg_en", 32'(clk_en), 32'd1);
        checkOutput("s6_rstg_gated", 32'(gated), 32'd0);
        checkOutput("s6_rstg_stats", 32'(stats), 32'd0);
        checkOutput("s6_rstg_state", 32'(dut.state), 32'(RUN));
        rst_n = 1'b1;

        // Statistics saturate; clear has priority over increment
        tick(2);
        checkOutput("s6_regated", 32'(gated), 32'd1);
        tick(20);
        checkOutput("s6_stat_sat", 32'(stats), 32'd15);
        stat_clr = 1'b1;
        tick(1);
        checkOutput("s6_stat_clr", 32'(stats), 32'd0);
        stat_clr = 1'b0;
        tick(1);
        checkOutput("s6_stat_inc", 32'(stats), 32'd1);

        // Asynchronous reset during WAKE
        idle = 1'b0;
        tick(2);
        checkOutput("s6_in_wake", 32'(dut.state), 32'(WAKE));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s6_rstw_en", 32'(clk_en), 32'd1);
        checkOutput("s6_rstw_gated", 32'(gated), 32'd0);
        checkOutput("s6_rstw_state", 32'(dut.state), 32'(RUN));
        rst_n = 1'b1;

        // Reset with an acknowledge outstanding clears it
        req = 1'b1;
        tick(2);
        checkOutput("s6_ack_before_rst", 32'(ack), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s6_ack_rst", 32'(ack), 32'd0);
        req = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        checkOutput("s6_ack_after_rst", 32'(ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
